// File: rtl/seq_mag_comparator.sv
`default_nettype none
// =============================================================================
// Module   : seq_mag_comparator
// Summary  : Multi-cycle signed/unsigned magnitude comparator that scans CHUNK
//            bits per clock, most-significant chunk first, with optional early exit.
// Revision : 1.0 - initial release
// =============================================================================
module seq_mag_comparator #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            signed_mode,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic                            busy,
    output logic                            done,
    output logic                            a_grt_b,
    output logic                            a_less_b,
    output logic                            a_eq_b,
    output logic [$clog2(WIDTH/CHUNK):0]    cycles
);

    localparam int c_NCH = WIDTH / CHUNK;
    localparam int c_CW  = $clog2(c_NCH) + 1;
    localparam int c_IW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [c_IW-1:0]    r_idx;
    logic [c_CW-1:0]    r_cycles;
    logic               r_diff_seen;
    logic               r_diff_gt;
    logic               r_gt;
    logic               r_lt;
    logic               r_eq;

    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic               w_chunk_gt;
    logic               w_chunk_lt;
    logic               w_last;
    logic               w_finish;
    logic               w_res_gt;
    logic               w_res_lt;
    logic               w_accept;

    // Flipping the sign bit of the top chunk maps two's-complement order onto
    // unsigned order; lower chunks are plain magnitude digits.
    always_comb begin
        w_chunk_a = r_a[WIDTH-1 -: CHUNK];
        w_chunk_b = r_b[WIDTH-1 -: CHUNK];
        if (r_signed && (r_idx == '0)) begin
            w_chunk_a[CHUNK-1] = ~w_chunk_a[CHUNK-1];
            w_chunk_b[CHUNK-1] = ~w_chunk_b[CHUNK-1];
        end
    end

    assign w_chunk_gt = (w_chunk_a > w_chunk_b);
    assign w_chunk_lt = (w_chunk_a < w_chunk_b);
    assign w_last     = (r_idx == c_LAST_IDX);

    // The first recorded difference always wins over the current chunk.
    assign w_res_gt   = r_diff_seen ? r_diff_gt  : w_chunk_gt;
    assign w_res_lt   = r_diff_seen ? ~r_diff_gt : w_chunk_lt;

    generate
        if (EARLY_EXIT != 0) begin : g_early_exit
            assign w_finish = w_last || w_chunk_gt || w_chunk_lt;
        end else begin : g_full_scan
            assign w_finish = w_last;
        end
    endgenerate

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (w_finish) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = start ? S_CMP : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_idx       <= '0;
            r_cycles    <= '0;
            r_diff_seen <= 1'b0;
            r_diff_gt   <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else if (w_accept) begin
            r_a         <= a;
            r_b         <= b;
            r_signed    <= signed_mode;
            r_idx       <= '0;
            r_cycles    <= '0;
            r_diff_seen <= 1'b0;
            r_diff_gt   <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_a      <= r_a << CHUNK;
            r_b      <= r_b << CHUNK;
            r_idx    <= r_idx + c_IW'(1);
            r_cycles <= r_cycles + c_CW'(1);
            if (!r_diff_seen && (w_chunk_gt || w_chunk_lt)) begin
                r_diff_seen <= 1'b1;
                r_diff_gt   <= w_chunk_gt;
            end
            if (w_finish) begin
                r_gt <= w_res_gt;
                r_lt <= w_res_lt;
                r_eq <= ~(w_res_gt | w_res_lt);
            end
        end
    end

    assign busy     = (r_state == S_CMP);
    assign done     = (r_state == S_DONE);
    assign a_grt_b  = r_gt;
    assign a_less_b = r_lt;
    assign a_eq_b   = r_eq;
    assign cycles   = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// =============================================================================
// Module   : tb_seq_mag_comparator
// Summary  : Scoreboard bench for seq_mag_comparator, early-exit and full-scan.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_seq_mag_comparator;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = $clog2(NCH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              st_e = 1'b0, sm_e = 1'b0;
    logic [WIDTH-1:0]  a_e = '0, b_e = '0;
    logic              busy_e, done_e, gt_e, lt_e, eq_e;
    logic [CW-1:0]     cyc_e;

    logic              st_f = 1'b0, sm_f = 1'b0;
    logic [WIDTH-1:0]  a_f = '0, b_f = '0;
    logic              busy_f, done_f, gt_f, lt_f, eq_f;
    logic [CW-1:0]     cyc_f;

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .start(st_e), .signed_mode(sm_e), .a(a_e), .b(b_e),
        .busy(busy_e), .done(done_e), .a_grt_b(gt_e), .a_less_b(lt_e),
        .a_eq_b(eq_e), .cycles(cyc_e)
    );

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) u_fs (
        .clk(clk), .rst(rst), .start(st_f), .signed_mode(sm_f), .a(a_f), .b(b_f),
        .busy(busy_f), .done(done_f), .a_grt_b(gt_f), .a_less_b(lt_f),
        .a_eq_b(eq_f), .cycles(cyc_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit gt;
        bit lt;
        bit eq;
        int cycles;
        int done_cyc;
    } exp_t;

    exp_t q_e[$];
    exp_t q_f[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ordering from integer arithmetic, latency from the position of
    // the most-significant differing chunk.
    function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                   logic sm, bit ee, int issue_cyc);
        exp_t e;
        logic [WIDTH-1:0] diff;
        int first;
        diff  = a ^ b;
        first = NCH;
        for (int i = 0; i < NCH; i++) begin
            if (first == NCH && diff[WIDTH-1-CHUNK*i -: CHUNK] != '0) first = i;
        end
        if (sm) begin
            e.gt = ($signed(a) > $signed(b));
            e.lt = ($signed(a) < $signed(b));
        end else begin
            e.gt = (a > b);
            e.lt = (a < b);
        end
        e.eq       = (a == b);
        e.cycles   = (ee && first < NCH) ? first + 1 : NCH;
        e.done_cyc = issue_cyc + 1 + e.cycles;
        return e;
    endfunction

    task automatic score(string tag, logic gt, logic lt, logic eq,
                         logic [CW-1:0] cy, logic bz, exp_t e);
        check({tag, "_gt"},      gt, e.gt);
        check({tag, "_lt"},      lt, e.lt);
        check({tag, "_eq"},      eq, e.eq);
        check({tag, "_cycles"},  cy, e.cycles);
        check({tag, "_busy"},    bz, 0);
        check({tag, "_latency"}, cyc, e.done_cyc);
    endtask

    always @(negedge clk) begin
        if (done_e === 1'b1) begin
            if (q_e.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL ee_unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                score("ee", gt_e, lt_e, eq_e, cyc_e, busy_e, q_e.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done_f === 1'b1) begin
            if (q_f.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL fs_unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                score("fs", gt_f, lt_f, eq_f, cyc_f, busy_f, q_f.pop_front());
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following E0.
    task automatic issue(bit ee, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sm);
        exp_t e;
        e = model(a, b, sm, ee, cyc);
        if (ee) begin
            st_e = 1'b1; a_e = a; b_e = b; sm_e = sm; q_e.push_back(e);
        end else begin
            st_f = 1'b1; a_f = a; b_f = b; sm_f = sm; q_f.push_back(e);
        end
        @(negedge clk); #1;
        if (ee) st_e = 1'b0; else st_f = 1'b0;
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_done(bit ee);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NCH + 4 && !ok; i++) begin
            @(negedge clk);
            if ((ee ? done_e : done_f) === 1'b1) ok = 1'b1;
        end
        #1;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles, expected done", ee ? "ee" : "fs", NCH + 4);
            if (ee) q_e.delete(); else q_f.delete();
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy_e"}, busy_e, 0);
        check({tag, "_done_e"}, done_e, 0);
        check({tag, "_flags_e"}, {gt_e, lt_e, eq_e}, 0);
        check({tag, "_cycles_e"}, cyc_e, 0);
        check({tag, "_busy_f"}, busy_f, 0);
        check({tag, "_flags_f"}, {gt_f, lt_f, eq_f}, 0);
        check({tag, "_cycles_f"}, cyc_f, 0);
    endtask

    task automatic random_run(bit ee, int n);
        logic [WIDTH-1:0] ra, rb;
        logic rs;
        int k;
        for (int t = 0; t < n; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = $urandom;
                2: begin
                    k  = $urandom_range(0, NCH - 1);
                    rb = ra ^ (WIDTH'(1) << ($urandom_range(0, CHUNK - 1) + CHUNK * k));
                end
                default: rb = ra ^ 32'h8000_0000;
            endcase
            rs = 1'($urandom_range(0, 1));
            issue(ee, ra, rb, rs);
            wait_done(ee);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) step();
            end
        end
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_all_zero("reset");
        repeat (3) step();
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // Sign bit decides immediately in unsigned mode.
        issue(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        check("t1_busy_after_e0", busy_e, 1);
        wait_done(1);
        step();
        check("t1_busy_one_cycle", busy_e, 0);
        check("t1_done_pulse", done_e, 0);
        check("t1_flag_hold", {gt_e, lt_e, eq_e}, 3'b100);

        issue(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        wait_done(1);
        step();

        issue(1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        wait_done(1);
        step();
        check("t3_done_single", done_e, 0);
        check("t3_eq_hold", {gt_e, lt_e, eq_e}, 3'b001);
        check("t3_cycles_hold", cyc_e, NCH);
        step();

        // Back-to-back: second start lands in the done cycle of the first.
        issue(1, 32'h1234_0000, 32'h1235_0000, 1'b0);
        wait_done(1);
        issue(1, 32'h1234_5679, 32'h1234_5678, 1'b0);
        check("t5_flags_cleared", {gt_e, lt_e, eq_e}, 0);
        check("t5_busy", busy_e, 1);
        wait_done(1);
        step();

        issue(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        wait_done(0);
        step();

        // A start pulse at E0+2 must be dropped.
        issue(1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        step();
        st_e = 1'b1; a_e = 32'h0; b_e = 32'hFFFF_FFFF; sm_e = 1'b1;
        step();
        st_e = 1'b0;
        wait_done(1);
        repeat (3) step();

        // Asynchronous abort in the middle of a full-length scan.
        issue(1, 32'h1111_1111, 32'h1111_1111, 1'b0);
        step();
        step();
        rst = 1'b1;
        q_e.delete();
        #1;
        check_all_zero("abort");
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < NCH + 2; i++) begin
            step();
            check("abort_idle_busy", busy_e, 0);
        end
        issue(1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_done(1);
        step();

        random_run(1, 150);
        random_run(0, 150);
        repeat (NCH + 4) step();
        check("ee_queue_drained", q_e.size(), 0);
        check("fs_queue_drained", q_f.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
